// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: sram-like instruction fetch port to a single-beat AXI read master.
// Latency: addr_ok cycle 0, arvalid 1, rready 2, data_ok 3 (min); hit-buffer hit gives data_ok on cycle 1.
// Backpressure: one fetch outstanding; inst_addr_ok only in IDLE, AR/R stall on arready/rvalid.
// Optional macro INST_HITBUF_EN adds a one-entry buffer of the last OKAY fetch.
module inst_axi_bridge #(
  parameter logic [3:0]  ARID      = 4'h0,
  parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic        inst_bus_err,
  input  logic        hb_flush,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_data_ok;
  logic        r_bus_err;
  logic [31:0] r_araddr;
  logic [31:0] r_rdata;

  logic [31:0] w_masked;
  logic        w_hit;
  logic        w_accept;
  logic        w_issue;
  logic        w_ar_hs;
  logic        w_r_hs;

  // Writes, size and the AXI id/last fields carry no information for a
  // word-only, single-beat, single-outstanding read path.
  logic        w_unused;
  assign w_unused = ^{inst_wr, inst_size, inst_wdata, rid, rlast, w_masked[1:0]};

  assign w_masked = inst_addr & ADDR_MASK;
  assign w_ar_hs  = r_arvalid & arready;
  assign w_r_hs   = r_rready & rvalid;

`ifdef INST_HITBUF_EN
  logic        r_hb_vld;
  logic [29:0] r_hb_tag;
  logic [31:0] r_hb_dat;

  // A flush in the request cycle suppresses the hit so a stale word is never returned.
  assign w_hit = r_hb_vld & ~hb_flush & (r_hb_tag == w_masked[31:2]);

  // Hit buffer: flush wins over a fill; only OKAY responses are cached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hb_vld <= 1'b0;
      r_hb_tag <= '0;
      r_hb_dat <= '0;
    end else if (hb_flush) begin
      r_hb_vld <= 1'b0;
    end else if (w_r_hs && (rresp == 2'b00)) begin
      r_hb_vld <= 1'b1;
      r_hb_tag <= r_araddr[31:2];
      r_hb_dat <= rdata;
    end
  end
`else
  logic w_unused_flush;
  assign w_unused_flush = hb_flush;
  assign w_hit          = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus accept/issue decode; requests are only taken in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = inst_req;
        if (inst_req && !w_hit) begin
          w_issue     = 1'b1;
          w_state_nxt = S_AR;
        end
      end
      S_AR: begin
        if (w_ar_hs) begin
          w_state_nxt = S_R;
        end
      end
      S_R: begin
        if (w_r_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // AXI channel handshakes and the registered one-cycle response pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_data_ok <= 1'b0;
      r_bus_err <= 1'b0;
      r_araddr  <= '0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= 1'b0;
      r_bus_err <= 1'b0;
      if (w_issue) begin
        r_araddr  <= {w_masked[31:2], 2'b00};
        r_arvalid <= 1'b1;
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_r_hs) begin
        r_rready  <= 1'b0;
        r_rdata   <= rdata;
        r_data_ok <= 1'b1;
        r_bus_err <= (rresp != 2'b00);
      end
`ifdef INST_HITBUF_EN
      if (w_accept && w_hit) begin
        r_rdata   <= r_hb_dat;
        r_data_ok <= 1'b1;
      end
`endif
    end
  end

  assign inst_addr_ok = w_accept;
  assign inst_data_ok = r_data_ok;
  assign inst_bus_err = r_bus_err;
  assign inst_rdata   = r_rdata;
  assign arid         = ARID;
  assign araddr       = r_araddr;
  assign arlen        = 4'd0;
  assign arsize       = 3'b010;
  assign arburst      = 2'b01;
  assign arvalid      = r_arvalid;
  assign rready       = r_rready;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge: directed plus randomized fetches against a per-transaction timing/buffer model.
// Latency model: addr_ok c0, arvalid c1..c1+ad, rready c2+ad..c2+ad+rd, data_ok c3+ad+rd (hit: c1).
// Backpressure: slave delays arready by ad and rvalid by rd cycles; held second requests must wait.
// Honours INST_HITBUF_EN when the design is built with it.
module tb_inst_axi_bridge;

`ifdef INST_HITBUF_EN
  localparam bit HBEN = 1'b1;
`else
  localparam bit HBEN = 1'b0;
`endif
  localparam logic [31:0] MASK = 32'h1FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic        inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'b10;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_wdata = '0;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        inst_bus_err;
  logic        hb_flush = 1'b0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  inst_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_bus_err(inst_bus_err),
    .hb_flush(hb_flush),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference hit-buffer contents and "already accepted" flag for chained requests.
  bit          hb_v = 1'b0;
  logic [29:0] hb_tag = '0;
  logic [31:0] hb_dat = '0;
  bit          pend = 1'b0;

  logic [31:0] pool [4] = '{32'h0000_0010, 32'h1FC0_0004, 32'h0000_0014, 32'h0ABC_DEE8};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    r       = pool[$urandom_range(0, 3)];
    r[31:29] = 3'($urandom);
    r[1:0]   = 2'($urandom);
    return r;
  endfunction

  // One fetch. ad = cycles arready is held low, rd = cycles rvalid lags rready.
  // b2b holds request na during the whole fetch so it is accepted on the data_ok cycle.
  // flr flushes in the request cycle, flf flushes in the R-handshake cycle.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs,
                     input int ad, input int rd, input bit b2b, input logic [31:0] na,
                     input bit flr, input bit flf);
    logic [31:0] m;
    logic [29:0] tag;
    logic [31:0] hd;
    bit          hit;
    int          lat;
    int          c0;
    bit          fl0;
    m   = a & MASK;
    tag = m[31:2];
    fl0 = flr && !pend;
    if (fl0) hb_v = 1'b0;
    hit = HBEN && hb_v && (hb_tag == tag);
    hd  = hb_dat;
    lat = hit ? 1 : 3 + ad + rd;
    c0  = pend ? 1 : 0;
    for (int c = c0; c <= lat; c++) begin
      inst_req   = (c == 0) || b2b;
      inst_addr  = (c == 0) ? a : (b2b ? na : $urandom);
      inst_wr    = 1'($urandom);
      inst_wdata = $urandom;
      hb_flush   = (c == 0 && fl0) || (!hit && flf && c == lat - 1);
      if (!hit && c >= 1 && c <= ad) arready = 1'b0;
      else if (!hit && c == 1 + ad)  arready = 1'b1;
      else                           arready = 1'($urandom);
      rvalid = !hit && (c == 2 + ad + rd);
      rdata  = rvalid ? d : $urandom;
      rresp  = rvalid ? rs : 2'($urandom);
      rid    = 4'($urandom);
      rlast  = 1'($urandom);
      #1;
      chk1("addr_ok", inst_addr_ok, (c == 0) || (c == lat && b2b));
      chk1("arvalid", arvalid, !hit && c >= 1 && c <= 1 + ad);
      if (!hit && c >= 1 && c <= 1 + ad) chk32("araddr", araddr, m & 32'hFFFF_FFFC);
      chk1("rready", rready, !hit && c >= 2 + ad && c < lat);
      chk1("data_ok", inst_data_ok, c == lat);
      chk1("bus_err", inst_bus_err, c == lat && !hit && rs != 2'b00);
      if (c == lat) chk32("rdata", inst_rdata, hit ? hd : d);
      @(posedge clk); #1;
    end
    if (HBEN && !hit) begin
      if (flf) hb_v = 1'b0;
      else if (rs == 2'b00) begin
        hb_v   = 1'b1;
        hb_tag = tag;
        hb_dat = d;
      end
    end
    pend = b2b;
  endtask

  task automatic idle(input int n, input bit fl);
    for (int i = 0; i < n; i++) begin
      inst_req = 1'b0;
      inst_addr = $urandom;
      hb_flush = fl;
      arready = 1'($urandom);
      rvalid = 1'b0;
      rdata = $urandom;
      rresp = 2'($urandom);
      #1;
      chk1("idle_addr_ok", inst_addr_ok, 1'b0);
      chk1("idle_arvalid", arvalid, 1'b0);
      chk1("idle_rready", rready, 1'b0);
      chk1("idle_data_ok", inst_data_ok, 1'b0);
      chk1("idle_bus_err", inst_bus_err, 1'b0);
      @(posedge clk); #1;
      if (fl) hb_v = 1'b0;
    end
    hb_flush = 1'b0;
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] nxt;
    bit          b2b;

    // Reset state.
    @(posedge clk); #1;
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_data_ok", inst_data_ok, 1'b0);
    chk1("rst_bus_err", inst_bus_err, 1'b0);
    chk32("rst_araddr", araddr, 32'h0);
    chk32("rst_rdata", inst_rdata, 32'h0);
    chk32("arlen", {28'h0, arlen}, 32'h0);
    chk32("arsize", {29'h0, arsize}, 32'h2);
    chk32("arburst", {30'h0, arburst}, 32'h1);
    chk32("arid", {28'h0, arid}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset asserted mid-AR abandons the fetch immediately.
    inst_req = 1'b1; inst_addr = 32'h8000_1234; arready = 1'b0;
    #1; chk1("mid_addr_ok", inst_addr_ok, 1'b1);
    @(posedge clk); #1;
    inst_req = 1'b0;
    #1; chk1("mid_arvalid1", arvalid, 1'b1);
    chk32("mid_araddr", araddr, 32'h0000_1234);
    @(posedge clk); #1;
    #1; chk1("mid_arvalid2", arvalid, 1'b1);
    rst = 1'b0;
    #1;
    chk1("arst_arvalid", arvalid, 1'b0);
    chk1("arst_rready", rready, 1'b0);
    chk1("arst_data_ok", inst_data_ok, 1'b0);
    chk32("arst_araddr", araddr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1; chk1("post_rst_arvalid", arvalid, 1'b0);
    @(posedge clk); #1;
    hb_v = 1'b0;
    pend = 1'b0;

    // Single minimum-latency fetch from the boot vector.
    txn(32'hBFC0_0004, 32'h2408_0001, 2'b00, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    // Backpressure with a second request held throughout, then accepted on data_ok.
    txn(32'h8000_0100, 32'h1111_2222, 2'b00, 5, 3, 1'b1, 32'h8000_0104, 1'b0, 1'b0);
    txn(32'h8000_0104, 32'h3333_4444, 2'b00, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    // Error response: data forwarded, bus_err pulses, nothing cached.
    txn(32'hBFC0_0008, 32'hDEAD_BEEF, 2'b10, 1, 1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    txn(32'hBFC0_0008, 32'hCAFE_0008, 2'b00, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    // Repeat fetch (hit when the buffer is built in), flush, refetch.
    txn(32'h8000_0010, 32'hA5A5_0010, 2'b00, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    txn(32'h8000_0010, 32'h5A5A_0010, 2'b00, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b1);
    txn(32'h8000_0010, 32'h0F0F_0010, 2'b00, 0, 1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    // Flush in the request cycle blocks a hit; flush on the fill edge blocks the fill.
    txn(32'hA000_0010, 32'h1234_5678, 2'b00, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(1, 1'b0);
    txn(32'h8000_0020, 32'h8765_4321, 2'b00, 1, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1, 1'b0);
    txn(32'h8000_0020, 32'h9999_0020, 2'b00, 0, 0, 1'b1, 32'h8000_0020, 1'b0, 1'b0);
    txn(32'h8000_0020, 32'h7777_0020, 2'b00, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);

    // Randomized fetches over a small aliased address pool.
    nxt = raddr();
    for (int i = 0; i < 40; i++) begin
      cur = nxt;
      nxt = raddr();
      b2b = (i < 39) && ($urandom_range(0, 2) == 0);
      txn(cur, $urandom,
          ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          b2b, nxt, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      if (!b2b) idle(int'($urandom_range(1, 2)), $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_axi_bridge.md
Name: inst_axi_bridge

Overview:
- Instruction-side bridge directly downstream of the fetch stage's sram-like master interface.
- Accepts one word-read request at a time on the sram-like `inst_*` bus and converts it to a single-beat AXI read transaction.
- Returns the fetched word to the fetch stage.
- Exactly one transaction outstanding; in-order by construction.

Parameters:
- ARID, 4'h0, value driven on arid for every transaction.
- ADDR_MASK, 32'h1FFF_FFFF, AND-mask applied to the request address before issue (kseg0/kseg1 physical fold).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; rst==0 resets immediately.
- inst_req  in  1  sram-like request valid.
- inst_wr  in  1  write flag; must be 0; a 1 is treated as a read.
- inst_size  in  2  transfer size; only 2'b10 (word) is supported.
- inst_addr  in  32  request byte address.
- inst_wdata  in  32  unused.
- inst_rdata  out  32  returned instruction word; valid while inst_data_ok=1.
- inst_addr_ok  out  1  request accepted this cycle.
- inst_data_ok  out  1  one-cycle pulse; data returned.
- inst_bus_err  out  1  one-cycle pulse coincident with inst_data_ok when rresp!=OKAY.
- hb_flush  in  1  hit-buffer invalidate (see Optional Feature).
- arid  out  4  ARID.
- araddr  out  32  {masked addr[31:2], 2'b00}.
- arlen  out  4  constant 0.
- arsize  out  3  constant 3'b010.
- arburst  out  2  constant 2'b01.
- arvalid  out  1  read address valid.
- arready  in  1  slave ready.
- rid  in  4  ignored.
- rdata  in  32  read data.
- rresp  in  2  read response.
- rlast  in  1  ignored; single beat.
- rvalid  in  1  read data valid.
- rready  out  1  master ready.

Behaviour:
- Reset values (rst==0):
  - state=IDLE.
  - arvalid, rready, inst_data_ok, inst_bus_err = 0.
  - araddr, inst_rdata = 0.
  - Hit buffer invalid.
- FSM states IDLE, AR, R.
- IDLE:
  - inst_addr_ok = inst_req, combinational, only in IDLE.
  - On inst_req: latch {addr & ADDR_MASK}[31:2] into araddr, set arvalid=1, go to AR.
- AR:
  - arvalid held high and araddr held stable until arready.
  - On arvalid&&arready: arvalid<=0, rready<=1, go to R.
- R:
  - On rvalid&&rready: inst_rdata<=rdata, inst_data_ok<=1, inst_bus_err<=(rresp!=2'b00), rready<=0, go to IDLE.
- inst_data_ok and inst_bus_err are registered and high for exactly one cycle.
- Data and error bit are forwarded regardless of rresp.
- inst_addr_ok is never high outside IDLE; a request arriving during AR/R waits (requester holds inst_req).
- A new request may be accepted in the same cycle inst_data_ok is high.
- Minimum latency with arready=1 and rvalid=1 immediately:
  - addr_ok cycle 0.
  - arvalid cycle 1.
  - rready cycle 2.
  - data_ok cycle 3.
- Reset asserted mid-transaction abandons it; the AXI slave shares the reset.
- Without the optional feature, hb_flush has no effect.

Optional Feature:
- Macro: INST_HITBUF_EN.
- When defined, a one-entry buffer holds {valid, addr[31:2], data} of the last fetch completed with rresp==OKAY.
- In IDLE, if inst_req && valid && masked addr[31:2]==buffered tag:
  - assert inst_addr_ok;
  - issue no AXI transaction and stay in IDLE;
  - next cycle drive inst_data_ok=1 with the buffered data, inst_bus_err=0.
- Miss: normal AXI path, then fill the buffer on completion.
- hb_flush=1 clears valid in the same edge.
- hb_flush has priority over a fill in the same cycle.
- A hit is not taken in the cycle hb_flush=1.
- Error responses never fill the buffer.
- When undefined: the buffer logic is absent, every request goes to AXI, and hb_flush is ignored.

Test Plan:
- Reset: rst=0 mid-AR with arvalid=1 -> arvalid, rready, inst_data_ok go to 0 immediately; state IDLE after release.
- Single fetch: inst_req, addr=32'hBFC0_0004; arready=1; rvalid next cycle with rdata=32'h2408_0001 -> araddr=32'h1FC0_0004; data_ok at cycle 3 with inst_rdata=32'h2408_0001.
- Backpressure: arready low 5 cycles, then rvalid delayed 3 cycles -> araddr stable throughout; inst_addr_ok=0 for a held second request until data_ok; single data_ok pulse.
- Error: rresp=2'b10 -> inst_data_ok=1 and inst_bus_err=1 for one cycle; rdata forwarded.
- Back-to-back: second inst_req held during the data_ok cycle -> accepted that cycle; second araddr issued the next cycle.
- INST_HITBUF_EN: fetch 32'h8000_0010 twice -> second fetch shows no arvalid and data_ok 1 cycle after addr_ok. After hb_flush, a third fetch issues arvalid.
